// File: rtl/fe_fetch_pkg.sv
// Shared types and constants for the b-risc instruction-fetch stage.
package fe_fetch_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   // Canonical NOP: ADDI x0,x0,0.
   localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Force a fetch address onto a word boundary.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
      return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
   endfunction

endpackage

// File: rtl/fe_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fe_fetch_if;
   import fe_fetch_pkg::*;

   logic               o_imem_req;
   logic [ADDR_W-1:0]  o_imem_addr;
   logic               i_imem_gnt;
   logic               i_imem_rvalid;
   logic [INSTR_W-1:0] i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_gnt,
      input  i_imem_rvalid,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_gnt,
      output i_imem_rvalid,
      output i_imem_rdata
   );

endinterface

// File: rtl/fe_fetch_fifo.sv
// Small synchronous FIFO with flush; head is the oldest entry, count the occupancy.
module fe_fifo
   import fe_fetch_pkg::*;
#(
   parameter int  WIDTH = ADDR_W + INSTR_W,
   parameter int  DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push+pop on a full FIFO is legal.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue and wins over push.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage is pure data and carries no reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fe_fetch.sv
// Instruction fetch: in-order imem requests, a response buffer, and the id-facing output register.
module fe_fetch
   import fe_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               stall,
   input  logic               i_redirect_en,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   fe_fetch_if.master         imem,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_valid
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = CNT_W + 2;
   localparam int ENT_W = $bits(fetch_entry_t);

   logic [ADDR_W-1:0] fetch_pc;
   logic [CNT_W-1:0]  drop;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  buf_count;
   logic [ADDR_W-1:0] req_addr_head;
   fetch_entry_t      buf_head;
   fetch_entry_t      resp_entry;
   logic [SUM_W-1:0]  in_use;
   logic              req;
   logic              issue;
   logic              resp_any;
   logic              resp_drop;
   logic              resp_keep;

   // Every slot that will eventually need buffer space counts: buffered words,
   // live requests and requests whose responses are still to be thrown away.
   assign in_use = SUM_W'(buf_count) + SUM_W'(outstanding) + SUM_W'(drop);
   assign req    = !clr && !i_redirect_en && (in_use < SUM_W'(FIFO_DEPTH));
   assign issue  = req && imem.i_imem_gnt;

   assign imem.o_imem_req  = req;
   assign imem.o_imem_addr = fetch_pc;

   // Responses return in order: stale ones (drop) are always older than live ones.
   assign resp_any  = imem.i_imem_rvalid && ((drop != '0) || (outstanding != '0));
   assign resp_drop = imem.i_imem_rvalid && (drop != '0);
   assign resp_keep = imem.i_imem_rvalid && (drop == '0) && (outstanding != '0);

   assign resp_entry.pc    = req_addr_head;
   assign resp_entry.instr = imem.i_imem_rdata;

   // Addresses of live requests; its occupancy is the outstanding count.
   fe_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (issue),
      .pop   (resp_keep),
      .flush (i_redirect_en),
      .din   (fetch_pc),
      .head  (req_addr_head),
      .count (outstanding)
   );

   // Returned instructions waiting for the output register.
   fe_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (resp_keep && !i_redirect_en),
      .pop   (!stall && !i_redirect_en),
      .flush (i_redirect_en),
      .din   (resp_entry),
      .head  (buf_head),
      .count (buf_count)
   );

   // Fetch PC and count of responses owed to a squashed stream.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         fetch_pc <= RESET_PC;
         drop     <= '0;
      end else if (i_redirect_en) begin
         fetch_pc <= align_pc(i_redirect_pc);
         drop     <= drop + outstanding - CNT_W'(resp_any);
      end else begin
         if (issue)     fetch_pc <= fetch_pc + ADDR_W'(4);
         if (resp_drop) drop     <= drop - CNT_W'(1);
      end
   end

   // Output register toward id: redirect squashes, stall holds, otherwise pop or bubble.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         o_valid <= 1'b0;
         o_instr <= INSTR_NOP;
         o_pc    <= RESET_PC;
      end else if (i_redirect_en) begin
         o_valid <= 1'b0;
         o_instr <= INSTR_NOP;
      end else if (!stall) begin
         if (buf_count != '0) begin
            o_valid <= 1'b1;
            o_instr <= buf_head.instr;
            o_pc    <= buf_head.pc;
         end else begin
            o_valid <= 1'b0;
            o_instr <= INSTR_NOP;
         end
      end
   end

   // A response with nothing in flight is a memory protocol violation.
   a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (clr)
      !(imem.i_imem_rvalid && (outstanding == '0) && (drop == '0)));

endmodule

// File: tb/tb_fe_fetch.sv
// Randomized bench for fe_fetch against a queue-based reference of the fetch stream.
module tb_fe_fetch;
   import fe_fetch_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        clr;
   logic        stall;
   logic        redir;
   logic [31:0] redir_pc;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic        o_valid;

   fe_fetch_if bus ();

   fe_fetch #(
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .clr           (clr),
      .stall         (stall),
      .i_redirect_en (redir),
      .i_redirect_pc (redir_pc),
      .imem          (bus),
      .o_pc          (o_pc),
      .o_instr       (o_instr),
      .o_valid       (o_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          live;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } mem_t;

   // Reference state: requests in flight (live or squashed), buffered words, output register.
   req_t        infl[$];
   ent_t        buff[$];
   mem_t        memq[$];
   logic [31:0] m_pc;
   logic [31:0] m_opc;
   logic [31:0] m_oinstr;
   bit          m_oval;
   int          cyc;

   // Stimulus knobs (percent probabilities) and an optional fixed redirect target.
   int          p_gnt;
   int          p_rv;
   int          p_stall;
   int          p_redir;
   bit          use_fix;
   logic [31:0] fix_pc;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      infl.delete();
      buff.delete();
      memq.delete();
      m_pc     = 32'h0;
      m_opc    = 32'h0;
      m_oinstr = INSTR_NOP;
      m_oval   = 1'b0;
   endtask

   // One clock cycle: entered just after a rising edge, leaves just after the next one.
   task automatic run_cycle();
      bit          exp_req;
      bit          rv;
      logic [31:0] rd;
      ent_t        e;
      req_t        r;

      if (clr) begin
         stall = 1'b0;
         redir = 1'b0;
         redir_pc = 32'h0;
         bus.i_imem_gnt = 1'b0;
         bus.i_imem_rvalid = 1'b0;
         bus.i_imem_rdata = 32'h0;
      end else begin
         stall = (($urandom % 100) < p_stall);
         redir = (($urandom % 100) < p_redir);
         case ($urandom % 4)
            0: redir_pc = 32'h0000_0103;
            1: redir_pc = 32'hFFFF_FFF4 | ($urandom & 32'h3);
            default: redir_pc = $urandom;
         endcase
         if (use_fix) redir_pc = fix_pc;
         bus.i_imem_gnt = (($urandom % 100) < p_gnt);
         if (memq.size() > 0 && memq[0].cyc < cyc && (($urandom % 100) < p_rv)) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = memq[0].addr ^ 32'hA5;
         end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = $urandom;
         end
      end

      #2;
      exp_req = !clr && !redir && ((buff.size() + infl.size()) < DEPTH);
      check("o_valid", 32'(o_valid), 32'(m_oval));
      check("o_instr", o_instr, m_oinstr);
      check("o_pc", o_pc, m_opc);
      check("imem_req", 32'(bus.o_imem_req), 32'(exp_req));
      check("imem_addr", bus.o_imem_addr, m_pc);

      if (!clr) begin
         rv = bus.i_imem_rvalid;
         rd = bus.i_imem_rdata;
         if (redir) begin
            m_oval   = 1'b0;
            m_oinstr = INSTR_NOP;
         end else if (!stall) begin
            if (buff.size() > 0) begin
               e        = buff.pop_front();
               m_opc    = e.pc;
               m_oinstr = e.instr;
               m_oval   = 1'b1;
            end else begin
               m_oinstr = INSTR_NOP;
               m_oval   = 1'b0;
            end
         end
         if (rv && infl.size() > 0) begin
            r = infl.pop_front();
            if (r.live && !redir) buff.push_back('{r.addr, rd});
         end
         if (redir) begin
            buff.delete();
            foreach (infl[i]) infl[i].live = 1'b0;
            m_pc = redir_pc & 32'hFFFF_FFFC;
         end else if (exp_req && bus.i_imem_gnt) begin
            infl.push_back('{m_pc, 1'b1});
            m_pc = m_pc + 32'd4;
         end
         if (rv && memq.size() > 0) void'(memq.pop_front());
         if (bus.o_imem_req && bus.i_imem_gnt) memq.push_back('{bus.o_imem_addr, cyc});
      end

      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_knobs(input int g, input int rvp, input int s, input int rd);
      p_gnt   = g;
      p_rv    = rvp;
      p_stall = s;
      p_redir = rd;
   endtask

   initial begin
      cyc = 0;
      use_fix = 1'b0;
      fix_pc = 32'h0;
      set_knobs(100, 100, 0, 0);
      stall = 1'b0;
      redir = 1'b0;
      redir_pc = 32'h0;
      bus.i_imem_gnt = 1'b0;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata = 32'h0;
      clr = 1'b0;
      model_reset();
      #1 clr = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) run_cycle();
      clr = 1'b0;

      // Back-to-back stream with one-cycle responses.
      repeat (40) run_cycle();

      // Stalls mid-stream.
      set_knobs(100, 100, 0, 0);
      repeat (3) run_cycle();
      set_knobs(100, 100, 100, 0);
      repeat (4) run_cycle();
      set_knobs(100, 80, 40, 0);
      repeat (200) run_cycle();

      // Redirect to 0x103 with two requests outstanding and responses held back.
      set_knobs(100, 0, 0, 0);
      repeat (3) run_cycle();
      use_fix = 1'b1;
      fix_pc  = 32'h0000_0103;
      set_knobs(100, 0, 0, 100);
      run_cycle();
      use_fix = 1'b0;
      set_knobs(100, 100, 0, 0);
      repeat (12) run_cycle();

      // Redirect coinciding with stall and a returning response.
      repeat (2) run_cycle();
      use_fix = 1'b1;
      fix_pc  = 32'h0000_0200;
      set_knobs(100, 100, 100, 100);
      run_cycle();
      use_fix = 1'b0;
      set_knobs(100, 100, 0, 0);
      repeat (12) run_cycle();

      // Fully random traffic with redirects.
      set_knobs(70, 60, 30, 8);
      repeat (1500) run_cycle();

      // Asynchronous reset between edges.
      #2;
      clr = 1'b1;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_gnt = 1'b0;
      redir = 1'b0;
      #1;
      model_reset();
      check("clr_async_valid", 32'(o_valid), 32'h0);
      check("clr_async_instr", o_instr, INSTR_NOP);
      check("clr_async_pc", o_pc, 32'h0);
      check("clr_async_req", 32'(bus.o_imem_req), 32'h0);
      @(posedge clk);
      #1;
      repeat (3) run_cycle();
      clr = 1'b0;

      set_knobs(70, 60, 30, 8);
      repeat (500) run_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
